// File: rtl/cram_arbiter.sv
// rtl/cram_arbiter.sv - shares the cart-RAM port between mapper and backup requesters; optional stats under CRAM_ARB_STATS_EN
module cram_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_cpu,
  input  logic              has_ram,
  input  logic [3:0]        ram_mask,
  input  logic              m_rd,
  input  logic              m_wr,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_di,
  output logic [DATA_W-1:0] m_do,
  output logic              m_valid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_di,
  output logic [DATA_W-1:0] b_do,
  output logic              b_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
`ifdef CRAM_ARB_STATS_EN
  ,
  output logic [15:0]       conflicts,
  output logic              overrun
`endif
);

  typedef enum logic [1:0] {IDLE, M_RD, B_RD, B_DONE} state_t;

  state_t              state;
  logic                pending;
  logic                p_rd;
  logic [ADDR_W-1:0]   p_addr;
  logic [DATA_W-1:0]   p_di;

  logic                capture;
  logic                m_issue;
  logic                m_ram;
  logic                b_issue;

  // Bank bits [16:13] are mirrored by the cart's RAM size mask; the rest pass through.
  function automatic logic [ADDR_W-1:0] mirror(input logic [ADDR_W-1:0] a, input logic [3:0] m);
    logic [ADDR_W-1:0] r;
    r        = a;
    r[16:13] = a[16:13] & m;
    return r;
  endfunction

  assign capture = ce_cpu & (m_rd | m_wr);
  assign m_issue = (state == IDLE) & pending;
  assign m_ram   = m_issue & has_ram;
  // Backup is held off while a mapper request waits and during its own ack cycle
  // (the requester still has b_req up then); reset_n keeps the port quiet in reset.
  assign b_issue = reset_n & (state == IDLE) & ~pending & b_req & ~b_ack;
  assign busy    = (state != IDLE) | pending;

  // RAM port decode: mapper has priority, backup only on an otherwise idle slot.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (m_ram) begin
      ram_en   = 1'b1;
      ram_we   = ~p_rd;
      ram_addr = mirror(p_addr, ram_mask);
      if (!p_rd) ram_wdata = p_di;
    end else if (b_issue) begin
      ram_en   = 1'b1;
      ram_we   = b_we;
      ram_addr = mirror(b_addr, ram_mask);
      if (b_we) ram_wdata = b_di;
    end
  end

  // Arbitration FSM, pending mapper slot and registered completion outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      p_rd    <= 1'b0;
      p_addr  <= '0;
      p_di    <= '0;
      m_do    <= {DATA_W{1'b1}};
      m_valid <= 1'b0;
      b_do    <= '0;
      b_ack   <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      b_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            // Slot is freed at issue so a capture landing in M_RD is never lost.
            pending <= 1'b0;
            if (p_rd) begin
              if (has_ram) begin
                state <= M_RD;
              end else begin
                m_do    <= {DATA_W{1'b1}};
                m_valid <= 1'b1;
              end
            end
          end else if (b_issue) begin
            state <= b_we ? B_DONE : B_RD;
          end
        end
        M_RD: begin
          m_do    <= ram_rdata;
          m_valid <= 1'b1;
          state   <= IDLE;
        end
        B_RD: begin
          b_do  <= ram_rdata;
          b_ack <= 1'b1;
          state <= IDLE;
        end
        B_DONE: begin
          b_ack <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A new strobe always wins the slot; a simultaneous write counts as a write.
      if (capture) begin
        pending <= 1'b1;
        p_rd    <= m_rd & ~m_wr;
        p_addr  <= m_addr;
        p_di    <= m_di;
      end
    end
  end

`ifdef CRAM_ARB_STATS_EN
  logic refused;
  assign refused = b_req & (((state == IDLE) & pending) | (state == M_RD));

  // Saturating refusal counter and sticky overwrite flag, cleared only by reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      conflicts <= '0;
      overrun   <= 1'b0;
    end else begin
      if (refused && conflicts != 16'hFFFF) conflicts <= conflicts + 16'd1;
      if (capture && pending && !m_issue) overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cram_arbiter.sv
// tb/tb_cram_arbiter.sv - scoreboard bench for cram_arbiter
module tb_cram_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ce_cpu;
  logic          has_ram;
  logic [3:0]    ram_mask;
  logic          m_rd;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_di;
  logic [DW-1:0] m_do;
  logic          m_valid;
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_di;
  logic [DW-1:0] b_do;
  logic          b_ack;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;
`ifdef CRAM_ARB_STATS_EN
  logic [15:0]   conflicts;
  logic          overrun;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_b_cyc = 0;
  int last_m_cyc = 0;

  typedef struct {
    logic [7:0] data;
    bit         rd;
    int         t0;
    int         lo;
    int         hi;
  } exp_t;

  exp_t exp_m[$];
  exp_t exp_b[$];

  logic [7:0] mem [0:131071];

  cram_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .has_ram(has_ram),
    .ram_mask(ram_mask), .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_di(m_di),
    .m_do(m_do), .m_valid(m_valid), .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_di(b_di), .b_do(b_do), .b_ack(b_ack), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
`ifdef CRAM_ARB_STATS_EN
    , .conflicts(conflicts), .overrun(overrun)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Cart RAM model: one-cycle read latency.
  always @(posedge clk_sys) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: pop on every completion pulse.
  always @(negedge clk_sys) begin
    exp_t e;
    int   lat;
    if (m_valid) begin
      last_m_cyc = cyc;
      if (exp_m.size() == 0) check("m_valid_unexpected", m_valid, 0);
      else begin
        e   = exp_m.pop_front();
        lat = cyc - e.t0;
        check("m_do", m_do, e.data);
        check("m_latency_in_range", (lat >= e.lo && lat <= e.hi), 1);
      end
    end
    if (b_ack) begin
      last_b_cyc = cyc;
      if (exp_b.size() == 0) check("b_ack_unexpected", b_ack, 0);
      else begin
        e   = exp_b.pop_front();
        lat = cyc - e.t0;
        if (e.rd) check("b_do", b_do, e.data);
        check("b_latency_in_range", (lat >= e.lo && lat <= e.hi), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic m_drive(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [7:0] d);
    ce_cpu = 1'b1; m_rd = rd; m_wr = wr; m_addr = a; m_di = d;
  endtask

  task automatic m_clear();
    ce_cpu = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
  endtask

  task automatic push_m(input logic [7:0] d, input int lo, input int hi);
    exp_t e;
    e.data = d; e.rd = 1'b1; e.t0 = cyc + 1; e.lo = lo; e.hi = hi;
    exp_m.push_back(e);
  endtask

  task automatic b_start(input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                         input logic [7:0] rd_exp, input int lo, input int hi);
    exp_t e;
    b_req = 1'b1; b_we = we; b_addr = a; b_di = d;
    e.data = rd_exp; e.rd = ~we; e.t0 = cyc; e.lo = lo; e.hi = hi;
    exp_b.push_back(e);
  endtask

  // Synchronous requester: drops b_req on the edge after it sees b_ack.
  task automatic wait_ack_drop();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_sys);
      if (b_ack) seen = 1'b1;
      else begin
        @(posedge clk_sys);
        #1;
      end
    end
    if (!seen) check("b_ack_timeout", b_ack, 1);
    @(posedge clk_sys);
    #1;
    b_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ce_cpu = 1'b0; has_ram = 1'b1; ram_mask = 4'hF;
    m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_di = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_di = '0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_m_do", m_do, 8'hFF);
    check("rst_b_do", b_do, 8'h00);
    check("rst_strobes", {m_valid, b_ack, ram_en, ram_we, busy}, 5'b0);
    check("rst_ram_addr", ram_addr, 17'h0);
    check("rst_ram_wdata", ram_wdata, 8'h00);
`ifdef CRAM_ARB_STATS_EN
    check("rst_conflicts", conflicts, 16'h0);
    check("rst_overrun", overrun, 1'b0);
`endif
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    tick();

    // Idle mapper write reaches RAM the next cycle.
    m_drive(0, 1, 17'h00005, 8'h3C);
    tick(); m_clear();
    @(negedge clk_sys);
    check("wr_ram_en", ram_en, 1'b1);
    check("wr_ram_we", ram_we, 1'b1);
    check("wr_ram_addr", ram_addr, 17'h00005);
    check("wr_ram_wdata", ram_wdata, 8'h3C);
    check("wr_busy", busy, 1'b1);
    tick();
    @(negedge clk_sys);
    check("wr_single_cycle", ram_en, 1'b0);
    check("wr_busy_clear", busy, 1'b0);
    tick();

    // Backup best case: write then read-back in two cycles each.
    b_start(1, 17'h00012, 8'hA7, 8'h00, 2, 2);
    @(negedge clk_sys);
    check("bwr_ram_addr", ram_addr, 17'h00012);
    check("bwr_ram_wdata", ram_wdata, 8'hA7);
    wait_ack_drop();
    b_start(0, 17'h00012, 8'h00, 8'hA7, 2, 2); wait_ack_drop();
    b_start(0, 17'h00005, 8'h00, 8'h3C, 2, 2); wait_ack_drop();

    // Idle mapper read, then m_do holds through idle and backup traffic.
    m_drive(1, 0, 17'h00012, 8'h00);
    push_m(8'hA7, 2, 2);
    tick(); m_clear();
    idle(4);
    check("m_do_hold_idle", m_do, 8'hA7);
    b_start(0, 17'h00005, 8'h00, 8'h3C, 2, 2); wait_ack_drop();
    check("m_do_hold_backup", m_do, 8'hA7);

    // Collision: backup write issues while a mapper read is captured.
    b_start(1, 17'h00030, 8'h3E, 8'h00, 2, 2);
    m_drive(1, 0, 17'h00030, 8'h00);
    push_m(8'h3E, 2, 4);
    @(negedge clk_sys);
    check("coll_backup_first_we", ram_we, 1'b1);
    check("coll_backup_first_addr", ram_addr, 17'h00030);
    @(posedge clk_sys); #1;
    m_clear();
    wait_ack_drop();
    idle(4);
    check("coll_order", (last_b_cyc < last_m_cyc), 1);
`ifdef CRAM_ARB_STATS_EN
    check("stats_conflicts_nonzero", (conflicts != 16'h0), 1);
`endif

    // Pending mapper write and b_req together: mapper first.
    m_drive(0, 1, 17'h00050, 8'h11);
    tick(); m_clear();
    b_start(0, 17'h00050, 8'h00, 8'h11, 2, 3);
    @(negedge clk_sys);
    check("simul_mapper_we", ram_we, 1'b1);
    check("simul_mapper_addr", ram_addr, 17'h00050);
    wait_ack_drop();
    idle(2);

    // Mirroring on both ports.
    ram_mask = 4'b0001;
    m_drive(0, 1, 17'h1E001, 8'h77);
    tick(); m_clear();
    @(negedge clk_sys);
    check("mirror_m_addr", ram_addr, 17'h02001);
    tick();
    b_start(0, 17'h1E001, 8'h00, 8'h77, 2, 2);
    @(negedge clk_sys);
    check("mirror_b_addr", ram_addr, 17'h02001);
    wait_ack_drop();
    ram_mask = 4'hF;
    b_start(0, 17'h02001, 8'h00, 8'h77, 2, 2); wait_ack_drop();

    // No cart RAM: write dropped, read returns FF, backup still served.
    has_ram = 1'b0;
    m_drive(0, 1, 17'h00005, 8'h00);
    tick(); m_clear();
    @(negedge clk_sys);
    check("noram_wr_dropped", ram_en, 1'b0);
    idle(3);
    m_drive(1, 0, 17'h00012, 8'h00);
    push_m(8'hFF, 1, 1);
    tick(); m_clear();
    @(negedge clk_sys);
    check("noram_rd_no_ram_en", ram_en, 1'b0);
    tick();
    @(negedge clk_sys);
    check("noram_rd_no_ram_en2", ram_en, 1'b0);
    tick();
    b_start(0, 17'h00005, 8'h00, 8'h3C, 2, 2); wait_ack_drop();
    has_ram = 1'b1;

    // Back-to-back captures: the first is lost, the second executes.
    b_start(1, 17'h00060, 8'hEE, 8'h00, 2, 2);
    m_drive(0, 1, 17'h00060, 8'h01);
    tick();
    m_drive(0, 1, 17'h00061, 8'h02);
    tick(); m_clear();
    wait_ack_drop();
    idle(3);
`ifdef CRAM_ARB_STATS_EN
    check("stats_overrun", overrun, 1'b1);
`endif
    b_start(0, 17'h00060, 8'h00, 8'hEE, 2, 2); wait_ack_drop();
    b_start(0, 17'h00061, 8'h00, 8'h02, 2, 2); wait_ack_drop();

    // Reset while a backup read is in B_RD: abandoned, no b_ack.
    b_req = 1'b1; b_we = 1'b0; b_addr = 17'h00012;
    tick();
    reset_n = 1'b0; b_req = 1'b0;
    #1;
    check("rstmid_m_do", m_do, 8'hFF);
    check("rstmid_b_do", b_do, 8'h00);
    check("rstmid_strobes", {m_valid, b_ack, ram_en, ram_we, busy}, 5'b0);
    check("rstmid_ram_addr", ram_addr, 17'h0);
`ifdef CRAM_ARB_STATS_EN
    check("rstmid_conflicts", conflicts, 16'h0);
    check("rstmid_overrun", overrun, 1'b0);
`endif
    idle(2);
    reset_n = 1'b1;
    idle(5);
    check("sb_m_empty", exp_m.size(), 0);
    check("sb_b_empty", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
